// File: rtl/icache.sv
// icache: direct-mapped, 16 one-word frames, read-only instruction cache.
// Define ICACHE_STATS_EN to build the saturating hit/miss performance counters.
module icache (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] FETCH = 1'b1;
   logic [0:0]  state_q, state_d;
   logic [31:0] miss_addr_q, miss_addr_d;
   logic [15:0] valid_q;
   logic [25:0] tag_q [16];
   logic [31:0] data_q [16];
   logic [3:0]  idx, fill_idx;
   logic        lookup_hit, miss, fill;
   assign idx        = imemaddr[5:2];
   assign fill_idx   = miss_addr_q[5:2];
   assign lookup_hit = valid_q[idx] && (tag_q[idx] == imemaddr[31:6]);
   assign ihit       = (state_q == IDLE) && imemREN && lookup_hit;
   assign imemload   = ihit ? data_q[idx] : '0;
   assign miss       = (state_q == IDLE) && imemREN && !lookup_hit;
   assign fill       = (state_q == FETCH) && !iwait;
   assign iREN       = (state_q == FETCH);
   assign iaddr      = iREN ? miss_addr_q : '0;
   always_comb begin
      state_d     = miss ? FETCH : fill ? IDLE : state_q;
      miss_addr_d = miss ? imemaddr : miss_addr_q;
   end
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q     <= IDLE;
         miss_addr_q <= '0;
         valid_q     <= '0;
         for (int i = 0; i < 16; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         miss_addr_q <= miss_addr_d;
         if (fill) begin
            valid_q[fill_idx] <= 1'b1;
            tag_q[fill_idx]   <= miss_addr_q[31:6];
            data_q[fill_idx]  <= iload;
         end
      end
   end
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count_q, miss_count_q;
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         if (ihit && hit_count_q != '1) hit_count_q <= hit_count_q + 32'd1;
         if (miss && miss_count_q != '1) miss_count_q <= miss_count_q + 32'd1;
      end
   end
   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif
endmodule
